// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Program-counter and instruction-fetch sequencer for the MIPS core. It keeps
// one fetch in flight at a time, holds the returned word for decode and
// selects the next PC: sequential, conditional branch, J-type jump or
// register jump. It is the only writer of the PC.
//
// Optional feature macro: PC_DELAY_SLOT_EN
//   defined   - a redirect takes effect after one delay-slot instruction; the
//               target is parked in a pending register until the slot is
//               accepted.
//   undefined - a redirect takes effect at the accept edge.
//
// Ports
//   clock         core clock, all state on the rising edge
//   reset         synchronous active-high reset
//   imem_req      fetch request to instruction memory
//   imem_addr     fetch address, stable while imem_req is high
//   imem_ready    imem_rdata valid, completes the request
//   imem_rdata    fetched instruction word
//   instr_valid   instr / instr_pc hold a fetched instruction
//   instr         held instruction word
//   instr_pc      address of the held instruction
//   instr_accept  decode consumes the held instruction this cycle
//   br_taken      with accept: conditional branch taken to br_target
//   br_target     branch target from execute
//   jump          with accept: J/JAL, target formed from instr
//   jr            with accept: JR/JALR to jr_target
//   jr_target     register value for jr
//   pc_plus4      instr_pc + 4 (link value / branch adder base)
//   addr_err      one-cycle pulse: a misaligned target was trapped
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_accept,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        addr_err_q, addr_err_d;

`ifdef PC_DELAY_SLOT_EN
    logic        pending_q, pending_d;
    logic [31:0] pending_target_q, pending_target_d;
`endif

    // Next-PC candidates
    logic [31:0] seq_pc;
    logic [31:0] jump_target;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        redirect_misaligned;
    logic        accept_fire;
    logic [31:0] next_pc;
    logic        next_err;

    assign seq_pc = instr_pc_q + 32'd4;

    // Region bits come from the delay-slot address (pc+4), not the jump itself.
    assign jump_target = {seq_pc[31:28], instr_q[25:0], 2'b00};

    // Decode can only consume a word that is actually being held.
    assign accept_fire = instr_accept && instr_valid_q && (state_q == StHold);

    // Redirect priority: jr > jump > br_taken. Only register and branch
    // targets can be misaligned; J-type targets always end in 2'b00.
    always_comb begin
        redirect            = 1'b0;
        redirect_target     = seq_pc;
        redirect_misaligned = 1'b0;
        if (jr) begin
            redirect            = 1'b1;
            redirect_target     = jr_target;
            redirect_misaligned = |jr_target[1:0];
        end else if (jump) begin
            redirect            = 1'b1;
            redirect_target     = jump_target;
        end else if (br_taken) begin
            redirect            = 1'b1;
            redirect_target     = br_target;
            redirect_misaligned = |br_target[1:0];
        end
    end

`ifdef PC_DELAY_SLOT_EN
    // A redirect first fetches the delay slot and parks the target. When the
    // slot itself is accepted, the parked target is used and any redirect
    // request on the slot is dropped.
    always_comb begin
        next_pc          = seq_pc;
        next_err         = 1'b0;
        pending_d        = pending_q;
        pending_target_d = pending_target_q;
        if (accept_fire) begin
            if (pending_q) begin
                next_pc   = pending_target_q;
                pending_d = 1'b0;
            end else if (redirect) begin
                pending_d        = 1'b1;
                pending_target_d = redirect_misaligned ? TRAP_PC : redirect_target;
                next_err         = redirect_misaligned;
            end
        end
    end
`else
    always_comb begin
        next_pc  = seq_pc;
        next_err = 1'b0;
        if (redirect) begin
            next_pc  = redirect_misaligned ? TRAP_PC : redirect_target;
            next_err = redirect_misaligned;
        end
    end
`endif

    // Main FSM next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        addr_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d     = StFetch;
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
            end
            StFetch: begin
                if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = StHold;
                end
            end
            StHold: begin
                if (accept_fire) begin
                    pc_d          = next_pc;
                    imem_addr_d   = next_pc;
                    imem_req_d    = 1'b1;
                    instr_valid_d = 1'b0;
                    addr_err_d    = next_err;
                    state_d       = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            addr_err_q    <= addr_err_d;
        end
    end

`ifdef PC_DELAY_SLOT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q        <= 1'b0;
            pending_target_q <= 32'd0;
        end else begin
            pending_q        <= pending_d;
            pending_target_q <= pending_target_d;
        end
    end
`endif

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = seq_pc;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Self-checking bench for pc_fetch_sequencer. A table of per-instruction
// records (returned word, redirect inputs, expected next fetch address and
// trap flag) is walked in order; expected fetch addresses go through a
// scoreboard queue and are compared when the DUT raises its next request.
// Hand-written sequences cover reset values and reset during a fetch.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0080;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_accept;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc_plus4;
    logic        addr_err;

    pc_fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .TRAP_PC  (TRAP_PC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_accept (instr_accept),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jump         (jump),
        .jr           (jr),
        .jr_target    (jr_target),
        .pc_plus4     (pc_plus4),
        .addr_err     (addr_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic        jreg;
        logic [31:0] jrt;
        logic [31:0] exp_next;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[16];
    int          n_vec = 0;
    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic add(input logic [31:0] rdata, input logic br, input logic [31:0] brt,
                       input logic jmp, input logic jreg, input logic [31:0] jrt,
                       input logic [31:0] exp_next, input logic exp_err);
        vecs[n_vec] = '{rdata, br, brt, jmp, jreg, jrt, exp_next, exp_err};
        n_vec++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        instr_accept = 1'b0;
        br_taken     = 1'b0;
        br_target    = 32'd0;
        jump         = 1'b0;
        jr           = 1'b0;
        jr_target    = 32'd0;
        imem_ready   = 1'b0;
    endtask

    // Bounded wait for a fetch request, sampled on the falling edge.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_req: got no request within 20 cycles, expected imem_req=1");
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] addr;
        bit          ok;
        wait_req(ok);
        if (!ok) return;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard[%0d]: got request, expected none queued", idx);
            return;
        end
        addr = exp_q.pop_front();
        check($sformatf("fetch_addr[%0d]", idx), imem_addr, addr);

        // Accept and redirects with nothing held must be ignored.
        instr_accept = 1'b1;
        jr           = 1'b1;
        jr_target    = 32'h0000_5550;
        @(negedge clock);
        clear_inputs();
        check($sformatf("fetch_stable_addr[%0d]", idx), imem_addr, addr);
        check($sformatf("fetch_stable_req[%0d]", idx), {31'd0, imem_req}, 32'd1);

        imem_ready = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clock);
        imem_ready = 1'b0;
        imem_rdata = ~v.rdata;
        check($sformatf("hold_valid[%0d]", idx), {31'd0, instr_valid}, 32'd1);
        check($sformatf("hold_instr[%0d]", idx), instr, v.rdata);
        check($sformatf("hold_instr_pc[%0d]", idx), instr_pc, addr);
        check($sformatf("hold_pc_plus4[%0d]", idx), pc_plus4, addr + 32'd4);
        check($sformatf("hold_req[%0d]", idx), {31'd0, imem_req}, 32'd0);

        // Late ready and redirects without accept must be ignored in HOLD.
        imem_ready = 1'b1;
        br_taken   = 1'b1;
        br_target  = 32'h0000_7770;
        jump       = 1'b1;
        @(negedge clock);
        clear_inputs();
        check($sformatf("hold_keep_valid[%0d]", idx), {31'd0, instr_valid}, 32'd1);
        check($sformatf("hold_keep_instr[%0d]", idx), instr, v.rdata);

        instr_accept = 1'b1;
        br_taken     = v.br;
        br_target    = v.brt;
        jump         = v.jmp;
        jr           = v.jreg;
        jr_target    = v.jrt;
        exp_q.push_back(v.exp_next);
        @(negedge clock);
        clear_inputs();
        check($sformatf("accept_valid[%0d]", idx), {31'd0, instr_valid}, 32'd0);
        check($sformatf("accept_req[%0d]", idx), {31'd0, imem_req}, 32'd1);
        check($sformatf("accept_err[%0d]", idx), {31'd0, addr_err}, {31'd0, v.exp_err});
        @(negedge clock);
        check($sformatf("err_pulse_end[%0d]", idx), {31'd0, addr_err}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        imem_rdata = 32'd0;
        clear_inputs();

`ifdef PC_DELAY_SLOT_EN
        //  rdata          br    brt            jmp   jr    jrt   next          err
        add(32'h0000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b0);
        add(32'h1000_0001, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 1'b0);
        add(32'h0000_0002, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 1'b0);
        add(32'h1000_0003, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0, 32'h0000_0104, 1'b0);
        add(32'h0000_0004, 1'b1, 32'h0000_0700, 1'b0, 1'b0, 32'h0, 32'h0000_0400, 1'b0);
        add(32'h1000_0005, 1'b1, 32'h0000_0206, 1'b0, 1'b0, 32'h0, 32'h0000_0404, 1'b1);
        add(32'h0000_0006, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, TRAP_PC,       1'b0);
        add(32'h0810_0040, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 32'h0000_0084, 1'b0);
        add(32'h0000_0007, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0040_0100, 1'b0);
`else
        //  rdata          br    brt            jmp   jr    jrt            next          err
        add(32'h2000_0001, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0004, 1'b0);
        add(32'h2000_0002, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0008, 1'b0);
        add(32'h2000_0003, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_000C, 1'b0);
        add(32'h0810_0040, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_1000, 1'b0);
        add(32'h0810_0040, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0,         32'h0040_0100, 1'b0);
        add(32'h2000_0004, 1'b1, 32'h0040_0010, 1'b0, 1'b0, 32'h0,         32'h0040_0010, 1'b0);
        add(32'h0810_0040, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0040_0100, 1'b0);
        add(32'h2000_0005, 1'b1, 32'h0000_0206, 1'b0, 1'b0, 32'h0,         TRAP_PC,       1'b1);
        add(32'h0810_0040, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_1003, TRAP_PC,       1'b1);
        add(32'h2000_0006, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        add(32'h2000_0007, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0);
        add(32'h2000_0008, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0FFF_FFFC, 32'h0FFF_FFFC, 1'b0);
        add(32'h0800_0010, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h1000_0040, 1'b0);
        add(32'h2000_0009, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h1000_0044, 1'b0);
`endif

        // Reset values
        @(negedge clock);
        @(negedge clock);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_pc_plus4", pc_plus4, 32'd4);
        check("rst_err", {31'd0, addr_err}, 32'd0);
        reset = 1'b0;
        exp_q.push_back(RESET_PC);

        for (int i = 0; i < n_vec; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in FETCH with imem_ready on the same edge
        begin
            bit ok;
            wait_req(ok);
        end
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_addr", imem_addr, RESET_PC);
        check("midrst_instr", instr, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        imem_ready = 1'b0;
        check("late_ready_valid", {31'd0, instr_valid}, 32'd0);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        run_vec('{32'h3000_0001, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b0}, 99);
        begin
            bit ok;
            wait_req(ok);
            if (ok) check("post_rst_next_addr", imem_addr, exp_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
